// File: rtl/serial_stream.sv
// serial_stream: fetches channel-interleaved sample words from SRAM over a Wishbone
// read master and shifts them out MSB-first on N_CH serial lanes. Build macro: SERIAL_LOOP_EN.
module serial_stream #(
  parameter int N_CH    = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 18,
  parameter int CLK_DIV = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [15:0]       n_frames_i,
  input  logic              loop_i,
  input  logic              stop_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o,
  output logic              sram_wb_cyc_o,
  output logic              sram_wb_stb_o,
  output logic              sram_wb_we_o,
  input  logic              sram_wb_ack_i,
  output logic [ADDR_W-1:0] sram_wb_adr_o,
  input  logic [DATA_W-1:0] sram_wb_dat_i,
  output logic              serial_clk_o,
  output logic              serial_frame_o,
  output logic [N_CH-1:0]   serial_dat_o
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_REQ  = 2'd1;
  localparam logic [1:0] F_FULL = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        r_fstate;
  logic [1:0]        r_sstate;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_fleft;
  logic [15:0]       r_sleft;
  logic [DATA_W-1:0] r_buf [N_CH];
  logic [DATA_W-1:0] r_sh  [N_CH];
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic              r_sclk;
  logic              r_busy;
  logic              r_ack;
  logic              r_done;
  logic              r_underrun;
  logic              r_stop;

  logic w_start;
  logic w_stop;
  logic w_full;
  logic w_loop;
  logic w_last;
  logic w_finish;
  logic w_bound;
  logic w_done;
  logic w_load;

`ifdef SERIAL_LOOP_EN
  logic              r_loop;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_nfr;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_loop <= 1'b0;
      r_base <= '0;
      r_nfr  <= '0;
    end else if (w_start) begin
      r_loop <= loop_i;
      r_base <= base_adr_i;
      r_nfr  <= n_frames_i;
    end
  end

  assign w_loop = r_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = loop_i;
  assign w_loop        = 1'b0;
`endif

  assign w_start  = wb_cyc_i & wb_stb_i & ~r_busy;
  assign w_stop   = r_stop | stop_i;
  assign w_full   = (r_fstate == F_FULL);
  assign w_last   = (r_sleft == 16'd0) & ~w_loop;
  assign w_finish = w_stop | w_last;
  // Frame boundary: first-frame wait, or the final cycle of a gap.
  assign w_bound  = (r_sstate == S_WAIT) | ((r_sstate == S_GAP) & (r_div == '0));
  // Never go idle with a read still outstanding on the SRAM bus.
  assign w_done   = w_bound & w_finish & (r_fstate != F_REQ);
  assign w_load   = w_bound & ~w_finish & w_full;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_fstate <= F_IDLE;
      r_ch     <= '0;
      r_addr   <= '0;
      r_fleft  <= '0;
      for (int c = 0; c < N_CH; c++) r_buf[c] <= '0;
    end else if (w_start) begin
      r_ch     <= '0;
      r_addr   <= base_adr_i;
      r_fleft  <= n_frames_i;
      r_fstate <= (n_frames_i != 16'd0) ? F_REQ : F_IDLE;
    end else begin
      case (r_fstate)
        F_REQ: begin
          if (sram_wb_ack_i) begin
            if (w_stop) begin
              r_fstate <= F_IDLE;
            end else begin
              r_buf[r_ch] <= sram_wb_dat_i;
              if (r_ch == CH_W'(N_CH - 1)) begin
                r_ch     <= '0;
                r_fstate <= F_FULL;
`ifdef SERIAL_LOOP_EN
                if (r_loop && (r_fleft == 16'd1)) begin
                  r_fleft <= r_nfr;
                  r_addr  <= r_base;
                end else begin
                  r_fleft <= r_fleft - 16'd1;
                  r_addr  <= r_addr + ADDR_W'(1);
                end
`else
                r_fleft <= r_fleft - 16'd1;
                r_addr  <= r_addr + ADDR_W'(1);
`endif
              end else begin
                r_ch   <= r_ch + CH_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
              end
            end
          end
        end
        F_FULL: begin
          if (w_stop)      r_fstate <= F_IDLE;
          else if (w_load) r_fstate <= (r_fleft != 16'd0) ? F_REQ : F_IDLE;
        end
        default: r_fstate <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sstate   <= S_IDLE;
      r_sleft    <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_sclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_stop     <= 1'b0;
      for (int c = 0; c < N_CH; c++) r_sh[c] <= '0;
    end else if (w_start) begin
      r_sstate   <= S_WAIT;
      r_sleft    <= n_frames_i;
      r_busy     <= 1'b1;
      r_ack      <= 1'b1;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (r_busy && stop_i) r_stop <= 1'b1;
      if (w_done) begin
        r_sstate <= S_IDLE;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
      end else if (w_load) begin
        for (int c = 0; c < N_CH; c++) r_sh[c] <= r_buf[c];
        r_sstate <= S_SHIFT;
        r_div    <= DIV_W'(CLK_DIV - 1);
        r_bit    <= BIT_W'(DATA_W - 1);
        r_sclk   <= 1'b0;
        if (r_sleft != 16'd0) r_sleft <= r_sleft - 16'd1;
      end else begin
        case (r_sstate)
          S_SHIFT: begin
            if (r_div != '0) begin
              r_div <= r_div - DIV_W'(1);
            end else begin
              r_div <= DIV_W'(CLK_DIV - 1);
              if (!r_sclk) begin
                r_sclk <= 1'b1;
              end else begin
                r_sclk <= 1'b0;
                if (r_bit == '0) begin
                  r_sstate <= S_GAP;
                  r_div    <= DIV_W'(2 * CLK_DIV - 1);
                end else begin
                  r_bit <= r_bit - BIT_W'(1);
                  for (int c = 0; c < N_CH; c++) r_sh[c] <= {r_sh[c][DATA_W-2:0], 1'b0};
                end
              end
            end
          end
          S_GAP: begin
            if (r_div != '0) begin
              r_div <= r_div - DIV_W'(1);
            end else begin
              // Buffer not ready at the end of a gap: wait with the frame low.
              r_sstate <= S_WAIT;
              if (!w_finish) r_underrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o       = r_ack;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign underrun_o     = r_underrun;
  assign sram_wb_cyc_o  = (r_fstate == F_REQ);
  assign sram_wb_stb_o  = (r_fstate == F_REQ);
  assign sram_wb_we_o   = 1'b0;
  assign sram_wb_adr_o  = r_addr;
  assign serial_clk_o   = r_sclk;
  assign serial_frame_o = (r_sstate == S_SHIFT);

  always_comb begin
    serial_dat_o = '0;
    for (int c = 0; c < N_CH; c++) serial_dat_o[c] = r_sh[c][DATA_W-1];
  end

endmodule
